// File: rtl/shift_seq_pkg.sv
// Shared types and encodings for the multi-bit shift sequencer.
// Lets the ALU top and the sequencer agree on the shift-unit function codes.
package shift_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] SU_SHR_A = 2'b00;
   localparam logic [1:0] SU_SHL_A = 2'b01;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_sequencer.sv
// Drives the single-bit shift unit once per bit position, feeding each result
// back as the next operand, and returns the final value on a valid/ready port.
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int ALU_WIDTH = 16,
   parameter int AMT_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ALU_WIDTH-1:0] req_data,
   input  logic                 req_dir,
   input  logic [AMT_WIDTH-1:0] req_amt,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [ALU_WIDTH-1:0] resp_data,
   output logic                 resp_err,
   output logic                 busy,
   output logic [ALU_WIDTH-1:0] su_a,
   output logic [ALU_WIDTH-1:0] su_b,
   output logic                 su_enable,
   output logic [1:0]           su_fun,
   input  logic [ALU_WIDTH-1:0] su_out,
   input  logic                 su_flag
);

   // Amounts at or beyond the datapath width shift everything out.
   localparam logic [AMT_WIDTH-1:0] AMT_LIMIT = AMT_WIDTH'(ALU_WIDTH);

   state_t               state_reg;
   logic [ALU_WIDTH-1:0] work_reg;
   logic [AMT_WIDTH-1:0] count_reg;
   logic                 dir_reg;
   logic [ALU_WIDTH-1:0] resp_data_reg;
   logic                 resp_err_reg;
   logic [ALU_WIDTH-1:0] su_a_reg;
   logic [1:0]           su_fun_reg;
   logic [AMT_WIDTH-1:0] count_next;

   assign count_next = count_reg - AMT_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         work_reg      <= '0;
         count_reg     <= '0;
         dir_reg       <= DIR_RIGHT;
         resp_data_reg <= '0;
         resp_err_reg  <= 1'b0;
         su_a_reg      <= '0;
         su_fun_reg    <= SU_SHR_A;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  work_reg  <= req_data;
                  dir_reg   <= req_dir;
                  count_reg <= req_amt;
                  if (req_amt == '0) begin
                     resp_data_reg <= req_data;
                     state_reg     <= DONE;
                  end else if (req_amt >= AMT_LIMIT) begin
                     resp_data_reg <= '0;
                     state_reg     <= DONE;
                  end else begin
                     // Operand and function are set up here so they are
                     // already stable when su_enable rises in ISSUE.
                     su_a_reg   <= req_data;
                     su_fun_reg <= (req_dir == DIR_LEFT) ? SU_SHL_A : SU_SHR_A;
                     state_reg  <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               state_reg <= WAIT;
            end
            WAIT: begin
               if (su_flag) begin
                  work_reg  <= su_out;
                  count_reg <= count_next;
                  if (count_next == '0) begin
                     resp_data_reg <= su_out;
                     state_reg     <= DONE;
                  end else begin
                     su_a_reg   <= su_out;
                     su_fun_reg <= (dir_reg == DIR_LEFT) ? SU_SHL_A : SU_SHR_A;
                     state_reg  <= ISSUE;
                  end
               end else begin
                  // Unit never flagged a result: abort with the last good value.
                  resp_err_reg  <= 1'b1;
                  resp_data_reg <= work_reg;
                  state_reg     <= DONE;
               end
            end
            DONE: begin
               if (resp_ready) begin
                  resp_err_reg <= 1'b0;
                  state_reg    <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign req_ready  = (state_reg == IDLE);
   assign busy       = (state_reg != IDLE);
   assign resp_valid = (state_reg == DONE);
   assign su_enable  = (state_reg == ISSUE);
   assign resp_data  = resp_data_reg;
   assign resp_err   = resp_err_reg;
   assign su_a       = su_a_reg;
   assign su_b       = '0;
   assign su_fun     = su_fun_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural single-bit shift unit
// whose flag can be suppressed to provoke the abort path.
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_data;
   logic        req_dir;
   logic [4:0]  req_amt;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_data;
   logic        resp_err;
   logic        busy;
   logic [15:0] su_a;
   logic [15:0] su_b;
   logic        su_enable;
   logic [1:0]  su_fun;
   logic [15:0] su_out;
   logic        su_flag;
   logic        kill_flag;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   shift_sequencer #(.ALU_WIDTH(16), .AMT_WIDTH(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data   (req_data),
      .req_dir    (req_dir),
      .req_amt    (req_amt),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .busy       (busy),
      .su_a       (su_a),
      .su_b       (su_b),
      .su_enable  (su_enable),
      .su_fun     (su_fun),
      .su_out     (su_out),
      .su_flag    (su_flag)
   );

   // Registered single-bit shift unit model.
   always @(posedge clk) begin
      su_flag <= su_enable && !kill_flag;
      if (su_enable)
         su_out <= (su_fun == 2'b01) ? (su_a << 1) : (su_a >> 1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
         $display("check %-12s obs=%0h exp=%0h ok", tag, obs, exp);
      end else begin
         $display("FAIL %-12s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Issue one request, observe enables and response, optionally stall the consumer.
   task automatic do_req(input logic [15:0] d, input logic dr, input logic [4:0] a,
                         input int hold, input logic kill,
                         input int exp_lat, input logic [31:0] exp_mask,
                         input logic [15:0] exp_data, input logic exp_err);
      logic [31:0] en_mask;
      int          lat;
      int          fun_bad;
      logic [15:0] first_data;
      en_mask = '0;
      lat     = 0;
      fun_bad = 0;
      @(negedge clk);
      check("req_ready", {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_data   = d;
      req_dir    = dr;
      req_amt    = a;
      resp_ready = (hold == 0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int i = 1; i < 40; i++) begin
         @(negedge clk);
         kill_flag = (i == 1) ? kill : 1'b0;
         if (su_enable) begin
            en_mask[i] = 1'b1;
            if (su_fun !== {1'b0, dr}) fun_bad++;
         end
         if (resp_valid) begin
            lat = i;
            break;
         end
      end
      kill_flag = 1'b0;
      check("latency", lat, exp_lat);
      check("en_mask", en_mask, exp_mask);
      check("su_fun", fun_bad, 0);
      check("resp_data", {16'd0, resp_data}, {16'd0, exp_data});
      check("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
      first_data = resp_data;
      for (int j = 0; j < hold; j++) begin
         @(negedge clk);
         check("hold_data", {16'd0, resp_data}, {16'd0, first_data});
         check("hold_rdy", {29'd0, req_ready, busy, resp_valid}, 32'b011);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      check("back_idle", {29'd0, req_ready, busy, resp_valid}, 32'b100);
      check("err_clr", {31'd0, resp_err}, 32'd0);
   endtask

   initial begin
      int seen;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_data   = '0;
      req_dir    = 1'b0;
      req_amt    = '0;
      resp_ready = 1'b1;
      kill_flag  = 1'b0;
      su_out     = '0;
      su_flag    = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_flags", {27'd0, req_ready, busy, resp_valid, su_enable, resp_err}, 32'b10000);
      check("rst_data", {16'd0, resp_data}, 32'd0);
      check("rst_su_a", {16'd0, su_a}, 32'd0);
      check("rst_su_fun", {30'd0, su_fun}, 32'd0);
      check("su_b", {16'd0, su_b}, 32'd0);

      do_req(16'h8001, 1'b1, 5'd3,  0, 1'b0, 7,  32'h0000_002A, 16'h0008, 1'b0);
      do_req(16'hF0F0, 1'b0, 5'd4,  0, 1'b0, 9,  32'h0000_00AA, 16'h0F0F, 1'b0);
      do_req(16'hABCD, 1'b1, 5'd0,  0, 1'b0, 1,  32'h0,         16'hABCD, 1'b0);
      do_req(16'hABCD, 1'b1, 5'd16, 0, 1'b0, 1,  32'h0,         16'h0000, 1'b0);
      do_req(16'h1357, 1'b0, 5'd31, 0, 1'b0, 1,  32'h0,         16'h0000, 1'b0);
      do_req(16'h1234, 1'b1, 5'd2,  0, 1'b1, 3,  32'h0000_0002, 16'h1234, 1'b1);
      do_req(16'h1234, 1'b0, 5'd1,  0, 1'b0, 3,  32'h0000_0002, 16'h091A, 1'b0);
      do_req(16'h00FF, 1'b1, 5'd8,  5, 1'b0, 17, 32'h0000_AAAA, 16'hFF00, 1'b0);
      do_req(16'hFFFF, 1'b0, 5'd15, 0, 1'b0, 31, 32'h2AAA_AAAA, 16'h0001, 1'b0);

      // Reset during the third ISSUE of an amt=5 request.
      @(negedge clk);
      req_valid = 1'b1;
      req_data  = 16'h0001;
      req_dir   = 1'b1;
      req_amt   = 5'd5;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("issue3_en", {31'd0, su_enable}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_mid", {28'd0, req_ready, busy, resp_valid, su_enable}, 32'b1000);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (resp_valid || busy) seen++;
      end
      check("no_resp", seen, 0);

      do_req(16'h0F00, 1'b0, 5'd2, 0, 1'b0, 5, 32'h0000_000A, 16'h03C0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
